// File: rtl/cmd_rx_if.sv
// Serial command receiver bus: tester line in, received word and status out.
interface cmd_rx_if;
  logic       in_rx;
  logic [5:0] out_data;
  logic       out_wrt_en;
  logic       out_frame_err;
  logic [7:0] out_err_cnt;
  logic       out_busy;

  modport master (
    output in_rx,
    input  out_data,
    input  out_wrt_en,
    input  out_frame_err,
    input  out_err_cnt,
    input  out_busy
  );

  modport slave (
    input  in_rx,
    output out_data,
    output out_wrt_en,
    output out_frame_err,
    output out_err_cnt,
    output out_busy
  );
endinterface

// File: rtl/cmd_rx.sv
// UART-style 6-bit command receiver with optional even parity.
// Good words pulse a write strobe; bad frames pulse an error and are counted.
module cmd_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic in_clk,
  input  logic in_rst,
  cmd_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] H_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] B_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [5:0]    r_shift;
  logic          r_par;
  logic [5:0]    r_data;
  logic          r_wrt;
  logic          r_ferr;
  logic [7:0]    r_err_cnt;

  logic w_bit_end;
  logic w_par_ok;

  assign w_bit_end = (r_cnt == B_M1);
  assign w_par_ok  = !PARITY_EN || !(^{r_shift, r_par});

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.in_rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_data    <= '0;
      r_wrt     <= 1'b0;
      r_ferr    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_wrt  <= 1'b0;
      r_ferr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          // Mid-start recheck: a short low pulse is a glitch, not a frame
          if (r_cnt == H_M1) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= r_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[5:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd5)
              r_state <= PARITY_EN ? PARITY : STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_par   <= r_rx_s;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          // A low stop bit may be a break; hold off until the line recovers
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? IDLE : WAIT_IDLE;
            if (r_rx_s && w_par_ok) begin
              r_data <= r_shift;
              r_wrt  <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
              if (r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (r_rx_s)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_data      = r_data;
  assign bus.out_wrt_en    = r_wrt;
  assign bus.out_frame_err = r_ferr;
  assign bus.out_err_cnt   = r_err_cnt;
  assign bus.out_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cmd_rx.sv
// Bench for cmd_rx: frame table plus corner sequences, checked by a
// per-unit scoreboard of expected strobes (kind, cycle, data, error count).
module tb_cmd_rx;
  localparam int C = 16;
  localparam int H = C / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_rx_if ifa ();
  cmd_rx_if ifb ();

  cmd_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut_a (
    .in_clk(clk),
    .in_rst(rst),
    .bus   (ifa)
  );

  cmd_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut_b (
    .in_clk(clk),
    .in_rst(rst),
    .bus   (ifb)
  );

  typedef struct {
    bit         good;
    logic [5:0] data;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [5:0] d;
    bit         pbad;
    bit         stop_v;
    bit         good;
    logic [5:0] xd;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   ecnt[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int qsize(input int u);
    return (u == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t qfront(input int u);
    return (u == 0) ? qa[0] : qb[0];
  endfunction

  task automatic qpop(input int u, output exp_t e);
    if (u == 0) e = qa.pop_front();
    else        e = qb.pop_front();
  endtask

  task automatic qpush(input int u, input exp_t e);
    if (u == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic mon(input int u, input logic wrt, input logic err,
                     input logic [5:0] d, input logic [7:0] cnt);
    exp_t e;
    while (qsize(u) > 0 && qfront(u).cyc < cyc) begin
      qpop(u, e);
      checks++;
      errors++;
      $display("FAIL missed_%0d: no strobe by cycle %0d, expected good=%0d data=%h",
               u, e.cyc, e.good, e.data);
    end
    if (wrt || err) begin
      checks++;
      if (qsize(u) == 0) begin
        errors++;
        $display("FAIL unexpected_%0d: wrt=%b err=%b at cycle %0d, expected none",
                 u, wrt, err, cyc);
      end else begin
        qpop(u, e);
        if (!e.good)
          ecnt[u] = (ecnt[u] == 255) ? 255 : ecnt[u] + 1;
        if (wrt !== e.good || err !== !e.good || cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe_%0d: wrt=%b err=%b cyc=%0d, expected wrt=%b err=%b cyc=%0d",
                   u, wrt, err, cyc, e.good, !e.good, e.cyc);
        end
        chk($sformatf("data_%0d", u), 32'(d), 32'(e.data));
        chk($sformatf("err_cnt_%0d", u), 32'(cnt), 32'(ecnt[u]));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ifa.out_wrt_en, ifa.out_frame_err, ifa.out_data, ifa.out_err_cnt);
      mon(1, ifb.out_wrt_en, ifb.out_frame_err, ifb.out_data, ifb.out_err_cnt);
    end
  end

  task automatic set_rx(input int u, input logic v);
    if (u == 0) ifa.in_rx = v;
    else        ifb.in_rx = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input logic [5:0] d, input bit pbad,
                      input bit stop_v, input bit good, input logic [5:0] xd);
    exp_t e;
    int   pen;
    pen    = (u == 0) ? 1 : 0;
    e.good = good;
    e.data = xd;
    e.cyc  = cyc + 1 + H + 2 + (7 + pen) * C;
    qpush(u, e);
    set_rx(u, 1'b0);
    hold(C);
    for (int i = 0; i < 6; i++) begin
      set_rx(u, d[i]);
      hold(C);
    end
    if (pen == 1) begin
      set_rx(u, (^d) ^ pbad);
      hold(C);
    end
    set_rx(u, stop_v);
    hold(C);
    if (!stop_v) begin
      set_rx(u, 1'b1);
      hold(C);
    end
  endtask

  initial begin
    vec_t vt[8];
    exp_t e;
    int   n;
    logic [5:0] dd;

    vt[0] = '{6'h2D, 1'b0, 1'b1, 1'b1, 6'h2D};
    vt[1] = '{6'h15, 1'b1, 1'b1, 1'b0, 6'h2D};
    vt[2] = '{6'h3F, 1'b0, 1'b1, 1'b1, 6'h3F};
    vt[3] = '{6'h00, 1'b0, 1'b1, 1'b1, 6'h00};
    vt[4] = '{6'h2A, 1'b0, 1'b1, 1'b1, 6'h2A};
    vt[5] = '{6'h2A, 1'b0, 1'b0, 1'b0, 6'h2A};
    vt[6] = '{6'h15, 1'b0, 1'b1, 1'b1, 6'h15};
    vt[7] = '{6'h3F, 1'b1, 1'b1, 1'b0, 6'h15};

    ecnt[0] = 0;
    ecnt[1] = 0;
    ifa.in_rx = 1'b1;
    ifb.in_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(ifa.out_data), 0);
    chk("rst_wrt", 32'(ifa.out_wrt_en), 0);
    chk("rst_ferr", 32'(ifa.out_frame_err), 0);
    chk("rst_cnt", 32'(ifa.out_err_cnt), 0);
    chk("rst_busy", 32'(ifa.out_busy), 0);
    chk("rst_busy_b", 32'(ifb.out_busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    hold(2);

    for (int i = 0; i < 8; i++)
      send(0, vt[i].d, vt[i].pbad, vt[i].stop_v, vt[i].good, vt[i].xd);
    hold(C);
    chk("tbl_err_cnt", 32'(ifa.out_err_cnt), 3);
    chk("tbl_data_held", 32'(ifa.out_data), 32'h15);

    // Short low pulse: busy for H cycles only
    n = 0;
    set_rx(0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i == 3) set_rx(0, 1'b1);
      @(negedge clk);
      if (ifa.out_busy) n++;
      @(posedge clk);
      #1;
    end
    chk("glitch_busy_cycles", 32'(n), 32'(H));
    chk("glitch_err_cnt", 32'(ifa.out_err_cnt), 3);

    // Break: one error, then parked until the line rises
    e.good = 1'b0;
    e.data = 6'h15;
    e.cyc  = cyc + 1 + H + 2 + 8 * C;
    qpush(0, e);
    set_rx(0, 1'b0);
    hold(20 * C);
    chk("break_wait_busy", 32'(ifa.out_busy), 1);
    set_rx(0, 1'b1);
    hold(4);
    chk("break_released", 32'(ifa.out_busy), 0);
    hold(C);
    send(0, 6'h01, 1'b0, 1'b1, 1'b1, 6'h01);
    hold(C);
    chk("break_err_cnt", 32'(ifa.out_err_cnt), 4);

    // Back-to-back, no gap
    send(0, 6'h01, 1'b0, 1'b1, 1'b1, 6'h01);
    send(0, 6'h3F, 1'b0, 1'b1, 1'b1, 6'h3F);
    hold(C);
    send(1, 6'h01, 1'b0, 1'b1, 1'b1, 6'h01);
    send(1, 6'h3F, 1'b0, 1'b1, 1'b1, 6'h3F);
    hold(C);
    chk("b2b_data_b", 32'(ifb.out_data), 32'h3F);

    // Reset in the middle of the data bits
    set_rx(0, 1'b0);
    hold(C);
    set_rx(0, 1'b1); hold(C);
    set_rx(0, 1'b0); hold(C);
    set_rx(0, 1'b1); hold(3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", 32'(ifa.out_data), 0);
    chk("mid_rst_wrt", 32'(ifa.out_wrt_en), 0);
    chk("mid_rst_ferr", 32'(ifa.out_frame_err), 0);
    chk("mid_rst_cnt", 32'(ifa.out_err_cnt), 0);
    chk("mid_rst_busy", 32'(ifa.out_busy), 0);
    chk("mid_rst_data_b", 32'(ifb.out_data), 0);
    set_rx(0, 1'b1);
    hold(3);
    ecnt[0] = 0;
    ecnt[1] = 0;
    rst = 1'b0;
    hold(10 * C);
    chk("post_rst_busy", 32'(ifa.out_busy), 0);
    chk("post_rst_data", 32'(ifa.out_data), 0);

    for (int i = 0; i < 256; i++) begin
      dd = 6'(i);
      send(0, dd, 1'b0, 1'b0, 1'b0, 6'h00);
    end
    hold(C);
    chk("sat_err_cnt", 32'(ifa.out_err_cnt), 255);
    chk("sat_data", 32'(ifa.out_data), 0);

    hold(200);
    chk("queue_empty", 32'(qa.size() + qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_rx.md
# cmd_rx

Serial command receiver for the FPGA tester front end. Deserializes a UART-style frame (start, 6 data bits LSB first, optional even parity, stop) from the tester's serial input. It presents each good 6-bit word with a one-cycle write strobe. `out_data`/`out_wrt_en` connect directly to the data input and write enable of the downstream 6-bit memory register stage.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, ≥ 4. `H = CLKS_PER_BIT/2`.
- `PARITY_EN`, 1: 1 = even parity bit present after data; 0 = no parity bit.
- `in_clk`  in  1  system clock, all logic on rising edge.
- `in_rst`  in  1  one clock; reset is asynchronous and active-high.
- `in_rx`  in  1  serial line, idle high, asynchronous to `in_clk`.
- `out_data`  out  6  last good received word; holds until next good frame.
- `out_wrt_en`  out  1  one-cycle strobe, `out_data` valid in same cycle.
- `out_frame_err`  out  1  one-cycle pulse on parity or stop-bit error.
- `out_err_cnt`  out  8  saturating count of frame errors.
- `out_busy`  out  1  high whenever state ≠ IDLE.

## Operation
- `in_rx` passes a 2-flop synchronizer (`rx_s`); both flops reset to 1.
- Bit counter `cnt`: width `$clog2(CLKS_PER_BIT)`. Bit index `idx`: 3 bits. Shift register: 6 bits, LSB first (new bit enters MSB, shifts right).
- States:
  - IDLE: `rx_s == 0` → START, `cnt = 0`.
  - START: `cnt` increments. At `cnt == H-1`: `rx_s == 0` → DATA, `cnt = 0`, `idx = 0`; `rx_s == 1` → IDLE (glitch). Glitch is silent: no error, no count.
  - DATA: at `cnt == CLKS_PER_BIT-1`, shift in `rx_s`, `cnt = 0`. After `idx == 5` → PARITY if `PARITY_EN`, else STOP.
  - PARITY: at `cnt == CLKS_PER_BIT-1`, latch `rx_s` as parity bit → STOP.
  - STOP: at `cnt == CLKS_PER_BIT-1`, evaluate the frame:
    - Good frame: `rx_s == 1` and XOR of 6 data bits plus parity bit == 0 (parity check only if `PARITY_EN`). Register `out_data` = shift reg, pulse `out_wrt_en`, → IDLE.
    - Parity error only (`rx_s == 1`): pulse `out_frame_err`, → IDLE.
    - Stop error (`rx_s == 0`): pulse `out_frame_err`, → WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s == 1`, then → IDLE. Prevents a held-low line or break from being taken as a new start.
- `out_err_cnt` increments on every `out_frame_err` and saturates at 255.
- `out_wrt_en` and `out_frame_err` are mutually exclusive and never asserted for two consecutive cycles.
- Reset at any time, including mid-frame:
  - State → IDLE; `cnt`, `idx`, shift reg → 0; synchronizer → 1.
  - All outputs → 0.
  - Partial frame is discarded without error.

## Timing
- Edge numbering: E0 is the rising edge that first samples `in_rx` low into sync flop 1.
- `rx_s` is low after E1; IDLE→START occurs at E2.
- START→DATA at E(H+2). Data bit k (k = 1..6) is sampled at E(H+2+k·C), where C = `CLKS_PER_BIT`.
- Parity is sampled at E(H+2+7C). Stop is sampled at E(H+2+(7+PARITY_EN)·C).
- `out_wrt_en`/`out_frame_err` are high for the one cycle after the stop-sample edge. With defaults: stop sample at E138, strobe high between E138 and E139.
- IDLE is entered at the stop-sample edge, so a start bit beginning half a bit later is fully captured. Back-to-back frames need no idle gap.
- `out_busy` rises after E2 and falls after the stop-sample edge; it stays high through WAIT_IDLE.

## Test plan
- Good frame, defaults, data 6'h2D, parity 0 → `out_data = 6'h2D`, `out_wrt_en` high exactly one cycle after E138, `out_frame_err = 0`, `out_err_cnt = 0`.
- Prior good word 6'h2D, then 6'h15 sent with parity 0 (wrong; correct parity is 1) → `out_frame_err` one-cycle pulse, no `out_wrt_en`, `out_data` stays 6'h2D, `out_err_cnt = 1`.
- `in_rx` low for 3 cycles then high → returns to IDLE at E(H+2), no strobe, no error, `out_busy` high for H cycles only.
- Line held low for 20 bit-times (break) → exactly one `out_frame_err`, FSM stays in WAIT_IDLE until `in_rx` rises. A following good 6'h01 frame is received correctly.
- Back-to-back 6'h01 then 6'h3F with no gap → two `out_wrt_en` pulses 144 cycles apart carrying 6'h01 and 6'h3F. Repeat with `PARITY_EN = 0` → pulses 128 cycles apart.
- Reset asserted mid-DATA of a frame, then 256 stop-error frames → all outputs 0 during reset and no strobe from the partial frame. `out_err_cnt` saturates at 255.
